// File: rtl/attr_datapath_scheduler_pkg.sv
// Shared types and helpers for the round-robin attributes datapath scheduler.
// The combine helper works at 32 bits; callers truncate to their own width.
package attr_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SUB,
    MUL,
    OUT
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Only the low W bits of the result are meaningful, and they depend only
  // on the low W bits of each argument.
  function automatic logic [31:0] combine(input logic [31:0] s0,
                                          input logic [31:0] s1,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    return (s0 - s1) + (a * b);
  endfunction

endpackage

// File: rtl/attr_datapath_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above PTR,
// wrapping around, when EN is high.
module rr_arbiter
  import attr_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]        REQ,
  input  logic [clog2(NREQ)-1:0] PTR,
  input  logic                   EN,
  output logic [NREQ-1:0]        GNT,
  output logic [clog2(NREQ)-1:0] IDX
);

  localparam int IDW = clog2(NREQ);

  logic           found;
  logic [IDW-1:0] cand;

  always_comb begin
    GNT   = '0;
    IDX   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(PTR) + k) % NREQ);
      if (EN && !found && REQ[cand]) begin
        found     = 1'b1;
        GNT[cand] = 1'b1;
        IDX       = cand;
      end
    end
  end

endmodule

// File: rtl/attr_datapath_scheduler.sv
// Shares one sequenced (A+B)-(A-B)+A*B datapath among NREQ requesters,
// granting round-robin and returning a tagged result over valid/ready.
module attr_datapath_scheduler
  import attr_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int CW   = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NREQ-1:0]        REQ_VALID,
  input  logic [NREQ*W-1:0]      REQ_A,
  input  logic [NREQ*W-1:0]      REQ_B,
  output logic [NREQ-1:0]        REQ_READY,
  output logic                   RES_VALID,
  input  logic                   RES_READY,
  output logic [W-1:0]           RES_DATA,
  output logic [clog2(NREQ)-1:0] RES_ID,
  output logic                   BUSY,
  output logic [CW-1:0]          DONE_COUNT
);

  localparam int IDW = clog2(NREQ);

  state_e         state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [IDW-1:0] id_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   s0_q;
  logic [W-1:0]   s1_q;
  logic [W-1:0]   resData_q;
  logic           resValid_q;
  logic           busy_q;
  logic [CW-1:0]  doneCnt_q;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grantIdx;
  logic            arbEn;
  logic [W-1:0]    selA;
  logic [W-1:0]    selB;

  // Grants are suppressed while reset is held so REQ_READY reads 0 in reset.
  assign arbEn = (state_q == IDLE) && RST_N;

  rr_arbiter #(
    .NREQ(NREQ)
  ) uArb (
    .REQ(REQ_VALID),
    .PTR(ptr_q),
    .EN (arbEn),
    .GNT(grant),
    .IDX(grantIdx)
  );

  assign selA  = REQ_A[int'(grantIdx)*W +: W];
  assign selB  = REQ_B[int'(grantIdx)*W +: W];
  assign ptr_d = (int'(grantIdx) == NREQ - 1) ? '0 : grantIdx + 1'b1;

  assign REQ_READY  = grant;
  assign RES_VALID  = resValid_q;
  assign RES_DATA   = resData_q;
  assign RES_ID     = id_q;
  assign BUSY       = busy_q;
  assign DONE_COUNT = doneCnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      s0_q       <= '0;
      s1_q       <= '0;
      resData_q  <= '0;
      resValid_q <= 1'b0;
      busy_q     <= 1'b0;
      doneCnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|grant) begin
            a_q     <= selA;
            b_q     <= selB;
            id_q    <= grantIdx;
            ptr_q   <= ptr_d;
            busy_q  <= 1'b1;
            state_q <= ADD;
          end
        end
        ADD: begin
          s0_q    <= a_q + b_q;
          state_q <= SUB;
        end
        SUB: begin
          s1_q    <= a_q - b_q;
          state_q <= MUL;
        end
        MUL: begin
          resData_q  <= W'(combine(32'(s0_q), 32'(s1_q), 32'(a_q), 32'(b_q)));
          resValid_q <= 1'b1;
          state_q    <= OUT;
        end
        OUT: begin
          if (RES_READY) begin
            resValid_q <= 1'b0;
            doneCnt_q  <= doneCnt_q + 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
